command_processor_program_loader: RTL and testbench

Upstream sequencer for the command processor memory controller. It accepts block commands from the host side (load, verify, dump), streams 32-bit words over valid/ready handshakes, and generates the `program_sel` / `cp_mem_ctrl_*` access sequence the controller decodes into SRAM and main-memory chip-selects. Reads honour the controller's one-cycle registered output select. Between commands `program_sel` is held at 2'b00, so every downstream SRAM stays deselected.

---
 rtl/command_processor_program_loader.sv | 180 ++++++++++++++++++
 tb/tb_command_processor_program_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_processor_program_loader.sv
// Host-side block sequencer (load / verify / dump) driving the command processor memory controller.
// Define LOADER_VERIFY_EN to build the verify op; otherwise op 01 is rejected like the reserved op.
module command_processor_program_loader #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_prog,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              abort,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [1:0]        program_sel,
  output logic              cp_mem_ctrl_we,
  output logic [ADDR_W-1:0] cp_mem_ctrl_addr,
  output logic [DATA_W-1:0] cp_mem_ctrl_in,
  input  logic [DATA_W-1:0] cp_mem_ctrl_out
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StRreq, StRcap, StVcmp, StDout, StFin
  } state_e;

  state_e            state_q;
  logic [1:0]        prog_q;
  logic [ADDR_W-1:0] cnt_q, rem_q, addr_q, err_addr_q;
  logic [DATA_W-1:0] data_q, in_q;
  logic              we_q, err_q;
`ifdef LOADER_VERIFY_EN
  logic              verify_q;
`endif

  logic              reserved_op;
  logic              last;
  logic [ADDR_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] rem_dec;
  logic              sel_active;

`ifdef LOADER_VERIFY_EN
  assign reserved_op = (cmd_op == 2'b11);
`else
  assign reserved_op = (cmd_op == 2'b11) || (cmd_op == 2'b01);
`endif

  assign last    = (rem_q == ADDR_W'(1));
  assign cnt_inc = cnt_q + ADDR_W'(1);
  assign rem_dec = rem_q - ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      prog_q     <= 2'b00;
      cnt_q      <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      err_addr_q <= '0;
      data_q     <= '0;
      in_q       <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_VERIFY_EN
      verify_q   <= 1'b0;
`endif
    end else if (abort) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          we_q <= 1'b0;
          if (cmd_valid) begin
            prog_q     <= cmd_prog;
            cnt_q      <= cmd_base;
            rem_q      <= cmd_len;
            addr_q     <= cmd_base;
            err_q      <= 1'b0;
            err_addr_q <= '0;
`ifdef LOADER_VERIFY_EN
            verify_q   <= (cmd_op == 2'b01);
`endif
            if (reserved_op) begin
              err_q      <= 1'b1;
              err_addr_q <= cmd_base;
              state_q    <= StFin;
            end else if (cmd_len == '0) begin
              state_q <= StFin;
            end else if (cmd_op == 2'b00) begin
              state_q <= StLoad;
            end else begin
              state_q <= StRreq;
            end
          end
        end
        StLoad: begin
          if (wr_valid) begin
            we_q   <= 1'b1;
            addr_q <= cnt_q;
            in_q   <= wr_data;
            cnt_q  <= cnt_inc;
            rem_q  <= rem_dec;
            if (last) state_q <= StFin;
          end else begin
            we_q <= 1'b0;
          end
        end
        StRreq: state_q <= StRcap;
        StRcap: begin
          // Controller output is registered: data for the RREQ address is valid now.
          data_q <= cp_mem_ctrl_out;
`ifdef LOADER_VERIFY_EN
          state_q <= verify_q ? StVcmp : StDout;
`else
          state_q <= StDout;
`endif
        end
`ifdef LOADER_VERIFY_EN
        StVcmp: begin
          if (wr_valid) begin
            if ((wr_data != data_q) && !err_q) begin
              err_q      <= 1'b1;
              err_addr_q <= cnt_q;
            end
            cnt_q   <= cnt_inc;
            rem_q   <= rem_dec;
            addr_q  <= cnt_inc;
            state_q <= last ? StFin : StRreq;
          end
        end
`endif
        StDout: begin
          if (rd_ready) begin
            cnt_q   <= cnt_inc;
            rem_q   <= rem_dec;
            addr_q  <= cnt_inc;
            state_q <= last ? StFin : StRreq;
          end
        end
        StFin: begin
          we_q    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The final load write lands in FIN, so the select stays up for that one write.
  assign sel_active = (state_q != StIdle) && ((state_q != StFin) || we_q);

  assign cmd_ready = (state_q == StIdle) && !abort;
`ifdef LOADER_VERIFY_EN
  assign wr_ready  = (state_q == StLoad) || (state_q == StVcmp);
`else
  assign wr_ready  = (state_q == StLoad);
`endif
  assign rd_valid         = (state_q == StDout);
  assign rd_data          = data_q;
  assign busy             = (state_q != StIdle);
  assign done             = (state_q == StFin) && !abort;
  assign err              = err_q;
  assign err_addr         = err_addr_q;
  assign program_sel      = (sel_active && !abort) ? prog_q : 2'b00;
  assign cp_mem_ctrl_we   = we_q && !abort;
  assign cp_mem_ctrl_addr = addr_q;
  assign cp_mem_ctrl_in   = in_q;

endmodule

// File: tb/tb_command_processor_program_loader.sv
// Directed bench for command_processor_program_loader with a registered-output memory model
// and write/read scoreboards.
`timescale 1ns/1ps
module tb_command_processor_program_loader;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [1:0]    cmd_prog = 2'b00;
  logic [AW-1:0] cmd_base = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          busy, done, err;
  logic [AW-1:0] err_addr;
  logic [1:0]    program_sel;
  logic          cp_mem_ctrl_we;
  logic [AW-1:0] cp_mem_ctrl_addr;
  logic [DW-1:0] cp_mem_ctrl_in;
  logic [DW-1:0] cp_mem_ctrl_out;

  command_processor_program_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_prog(cmd_prog),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .abort(abort),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .program_sel(program_sel), .cp_mem_ctrl_we(cp_mem_ctrl_we),
    .cp_mem_ctrl_addr(cp_mem_ctrl_addr), .cp_mem_ctrl_in(cp_mem_ctrl_in),
    .cp_mem_ctrl_out(cp_mem_ctrl_out)
  );

  always #5 clk = ~clk;

  // Controller model: one bank per program select, one-cycle registered read data.
  logic [DW-1:0] mem [4][1<<AW];
  always @(posedge clk) begin
    cp_mem_ctrl_out <= mem[program_sel][cp_mem_ctrl_addr];
    if (cp_mem_ctrl_we && program_sel != 2'b00) mem[program_sel][cp_mem_ctrl_addr] = cp_mem_ctrl_in;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    rq[$];
  logic [1:0]       wprog = 2'b01;
  logic [AW+DW-1:0] wexp;
  int cyc = 0, done_cnt = 0, done_cyc = 0, wr_hs = 0, last_we = -10, run = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (cp_mem_ctrl_we) begin
        if (cyc == last_we + 1) run++; else run = 1;
        last_we = cyc;
        if (wq.size() == 0) chk("we_unexpected", cp_mem_ctrl_we, 0);
        else begin
          wexp = wq.pop_front();
          chk("we_addr", cp_mem_ctrl_addr, wexp[AW+DW-1:DW]);
          chk("we_data", cp_mem_ctrl_in, wexp[DW-1:0]);
          chk("we_sel", program_sel, wprog);
        end
      end
      if (wr_valid && wr_ready) wr_hs++;
      if (rd_valid && prev_hold) chk("rd_hold", rd_data, prev_rd);
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0) chk("rd_unexpected", rd_valid, 0);
        else chk("rd_data", rd_data, rq.pop_front());
      end
      prev_hold = rd_valid && !rd_ready;
      prev_rd   = rd_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [AW+DW-1:0] wr_ent(input int a, input logic [DW-1:0] d);
    return {AW'(a), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] prog,
                       input logic [AW-1:0] base, input logic [AW-1:0] len);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_op = op; cmd_prog = prog; cmd_base = base; cmd_len = len;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, h0;
    bit seen, v, hs;
    for (int i = 0; i < 3; i++) mem[2][i] = 32'hD00D_0000 | i;

    // Reset state
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_sel", program_sel, 0);
    chk("rst_we", cp_mem_ctrl_we, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Load across 0x1FF/0x200
    wprog = 2'b01;
    for (int i = 0; i < 4; i++) wq.push_back(wr_ent(14'h1FE + i, 32'hA0A0_0000 + i));
    d0 = done_cnt;
    issue(2'b00, 2'b01, 14'h1FE, 14'd4);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA0A0_0000 + i;
      tick();
    end
    wr_valid = 1'b0;
    wait_done(8);
    tick();
    chk("load_err", err, 0);
    chk("load_run", run, 4);
    chk("load_done_with_last_write", done_cyc, last_we);
    chk("load_wq_empty", wq.size(), 0);
    chk("load_sel_idle", program_sel, 0);
    tick(); tick();
    chk("load_done_once", done_cnt - d0, 1);

    // Dump with toggling backpressure
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) rq.push_back(32'hD00D_0000 | i);
    issue(2'b10, 2'b10, 14'h000, 14'd3);
    chk("dump_sel", program_sel, 2'b10);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
      @(posedge clk);
      #1;
      rd_ready = ~rd_ready;
    end
    chk("dump_done", seen, 1);
    rd_ready = 1'b0;
    chk("dump_sel_after", program_sel, 0);
    chk("dump_rq_empty", rq.size(), 0);

    // Verify against the words loaded above, host word 2 corrupted
    h0 = wr_hs;
`ifdef LOADER_VERIFY_EN
    issue(2'b01, 2'b01, 14'h1FE, 14'd3);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = (i == 1) ? (32'hA0A0_0001 ^ 32'h1) : (32'hA0A0_0000 + i);
      hs = 1'b0;
      for (int j = 0; j < 20 && !hs; j++) begin
        @(negedge clk);
        hs = wr_ready;
        @(posedge clk);
        #1;
      end
      chk("vfy_hs", hs, 1);
    end
    wr_valid = 1'b0;
    wait_done(10);
    chk("vfy_err", err, 1);
    chk("vfy_err_addr", err_addr, 14'h1FF);
    chk("vfy_consumed", wr_hs - h0, 3);
`else
    wr_valid = 1'b1;
    wr_data  = 32'h1234_5678;
    issue(2'b01, 2'b01, 14'h1FE, 14'd3);
    @(negedge clk);
    chk("vfy_off_done", done, 1);
    chk("vfy_off_err", err, 1);
    chk("vfy_off_err_addr", err_addr, 14'h1FE);
    tick(); tick();
    wr_valid = 1'b0;
    chk("vfy_off_consumed", wr_hs - h0, 0);
`endif
    tick();

    // Address wrap
    wprog = 2'b01;
    wq.push_back(wr_ent(14'h3FFF, 32'hC0DE_0000));
    wq.push_back(wr_ent(14'h0000, 32'hC0DE_0001));
    issue(2'b00, 2'b01, 14'h3FFF, 14'd2);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hC0DE_0000 + i;
      tick();
    end
    wr_valid = 1'b0;
    wait_done(8);
    tick();
    chk("wrap_run", run, 2);
    chk("wrap_wq_empty", wq.size(), 0);
    chk("wrap_err_cleared", err, 0);

    // Zero length
    issue(2'b00, 2'b01, 14'h0055, 14'd0);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_err", err, 0);
    tick();
    chk("len0_idle", busy, 0);

    // Reserved op
    issue(2'b11, 2'b10, 14'h0123, 14'd5);
    @(negedge clk);
    chk("op11_done", done, 1);
    chk("op11_err", err, 1);
    chk("op11_err_addr", err_addr, 14'h0123);
    tick();

    // Abort mid-dump
    rd_ready = 1'b0;
    d0 = done_cnt;
    issue(2'b10, 2'b10, 14'h000, 14'd3);
    chk("abort_err_cleared", err, 0);
    v = 1'b0;
    for (int j = 0; j < 10 && !v; j++) begin
      @(negedge clk);
      v = rd_valid;
    end
    chk("abort_rd_valid_up", v, 1);
    tick();
    abort = 1'b1;
    #1;
    chk("abort_sel_now", program_sel, 0);
    chk("abort_we_now", cp_mem_ctrl_we, 0);
    tick();
    chk("abort_rd_valid_drop", rd_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_blocks_cmd", cmd_ready, 0);
    abort = 1'b0;
    #1;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_no_done", done_cnt - d0, 0);
    tick();

    // Reset mid-load
    wprog = 2'b01;
    wq.push_back(wr_ent(14'h0040, 32'hB0B0_0000));
    issue(2'b00, 2'b01, 14'h0040, 14'd4);
    wr_valid = 1'b1;
    wr_data  = 32'hB0B0_0000;
    tick();
    wr_data  = 32'hB0B0_0001;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_we", cp_mem_ctrl_we, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_sel", program_sel, 0);
    chk("rst_mid_addr", cp_mem_ctrl_addr, 0);
    chk("rst_mid_in", cp_mem_ctrl_in, 0);
    chk("rst_mid_wr_ready", wr_ready, 0);
    wr_valid = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_wq_empty", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
